// File: rtl/nova_bus_pkg.sv
// Shared definitions for the core's memory bus: default widths, the
// arbiter state encoding and the full byte-enable pattern used for fetches.
package nova_bus_pkg;

   localparam int unsigned DEF_AW = 32;
   localparam int unsigned DEF_DW = 32;
   localparam int unsigned DEF_BW = DEF_DW / 8;

   localparam logic [DEF_BW-1:0] BE_ALL_ONES = '1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BUSY_I = 3'd1,
      ST_BUSY_D = 3'd2,
      ST_RESP_I = 3'd3,
      ST_RESP_D = 3'd4
   } arb_state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting on the memory; flags when TIMEOUT-1 is reached.
module bus_timeout_counter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired_c
);

   localparam int unsigned CW = $clog2(TIMEOUT);

   logic [CW-1:0] r_count;

   // Saturates at the expiry value so a stalled enable cannot wrap it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired_c) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_expired_c = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and data (D):
// D has priority, bounded by a streak limit, and stalled accesses time out.
module mem_arbiter
   import nova_bus_pkg::*;
#(
   parameter int unsigned AW           = DEF_AW,
   parameter int unsigned DW           = DEF_DW,
   parameter int unsigned D_STREAK_MAX = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_ack,
   output logic [DW-1:0]   i_rdata,
   output logic            i_err,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_ack,
   output logic [DW-1:0]   d_rdata,
   output logic            d_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic            mem_ack,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned SW = $clog2(D_STREAK_MAX + 1);

   // Package constant is sized for the default bus; widen by replication.
   localparam logic [BW-1:0] L_BE_ALL = BW'({(BW / DEF_BW + 1){BE_ALL_ONES}});

   arb_state_t    r_state,     w_state;
   logic [SW-1:0] r_streak,    w_streak;
   logic          r_mem_req,   w_mem_req;
   logic          r_mem_we,    w_mem_we;
   logic [AW-1:0] r_mem_addr,  w_mem_addr;
   logic [DW-1:0] r_mem_wdata, w_mem_wdata;
   logic [BW-1:0] r_mem_be,    w_mem_be;
   logic          r_i_ack,     w_i_ack;
   logic [DW-1:0] r_i_rdata,   w_i_rdata;
   logic          r_i_err,     w_i_err;
   logic          r_d_ack,     w_d_ack;
   logic [DW-1:0] r_d_rdata,   w_d_rdata;
   logic          r_d_err,     w_d_err;

   logic w_busy;
   logic w_expired;

   assign w_busy = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);

   bus_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (!w_busy),
      .i_enable    (w_busy),
      .o_expired_c (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_streak    <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_i_ack     <= 1'b0;
         r_i_rdata   <= '0;
         r_i_err     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_d_rdata   <= '0;
         r_d_err     <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_streak    <= w_streak;
         r_mem_req   <= w_mem_req;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_mem_be    <= w_mem_be;
         r_i_ack     <= w_i_ack;
         r_i_rdata   <= w_i_rdata;
         r_i_err     <= w_i_err;
         r_d_ack     <= w_d_ack;
         r_d_rdata   <= w_d_rdata;
         r_d_err     <= w_d_err;
      end
   end

   // Acks are raised on the BUSY->RESP edge so they are visible for exactly
   // the RESP cycle; response data and err are held until the next response.
   always_comb begin
      w_state     = r_state;
      w_streak    = r_streak;
      w_mem_req   = r_mem_req;
      w_mem_we    = r_mem_we;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_mem_be    = r_mem_be;
      w_i_ack     = 1'b0;
      w_i_rdata   = r_i_rdata;
      w_i_err     = r_i_err;
      w_d_ack     = 1'b0;
      w_d_rdata   = r_d_rdata;
      w_d_err     = r_d_err;

      case (r_state)
         ST_IDLE: begin
            if (d_req && ((r_streak < SW'(D_STREAK_MAX)) || !i_req)) begin
               w_state     = ST_BUSY_D;
               w_mem_req   = 1'b1;
               w_mem_we    = d_we;
               w_mem_addr  = d_addr;
               w_mem_wdata = d_wdata;
               w_mem_be    = d_be;
               if (!i_req) begin
                  w_streak = '0;
               end else if (r_streak != SW'(D_STREAK_MAX)) begin
                  w_streak = r_streak + SW'(1);
               end
            end else if (i_req) begin
               w_state     = ST_BUSY_I;
               w_mem_req   = 1'b1;
               w_mem_we    = 1'b0;
               w_mem_addr  = i_addr;
               w_mem_wdata = '0;
               w_mem_be    = L_BE_ALL;
               w_streak    = '0;
            end
         end

         ST_BUSY_I: begin
            if (mem_ack) begin
               w_state   = ST_RESP_I;
               w_mem_req = 1'b0;
               w_i_ack   = 1'b1;
               w_i_rdata = mem_rdata;
               w_i_err   = 1'b0;
            end else if (w_expired) begin
               w_state   = ST_RESP_I;
               w_mem_req = 1'b0;
               w_i_ack   = 1'b1;
               w_i_rdata = '0;
               w_i_err   = 1'b1;
            end
         end

         ST_BUSY_D: begin
            if (mem_ack) begin
               w_state   = ST_RESP_D;
               w_mem_req = 1'b0;
               w_mem_we  = 1'b0;
               w_d_ack   = 1'b1;
               w_d_rdata = r_mem_we ? '0 : mem_rdata;
               w_d_err   = 1'b0;
            end else if (w_expired) begin
               w_state   = ST_RESP_D;
               w_mem_req = 1'b0;
               w_mem_we  = 1'b0;
               w_d_ack   = 1'b1;
               w_d_rdata = '0;
               w_d_err   = 1'b1;
            end
         end

         ST_RESP_I, ST_RESP_D: begin
            w_state = ST_IDLE;
         end

         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;
   assign i_ack     = r_i_ack;
   assign i_rdata   = r_i_rdata;
   assign i_err     = r_i_err;
   assign d_ack     = r_d_ack;
   assign d_rdata   = r_d_rdata;
   assign d_err     = r_d_err;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch side (I, read-only) and data load/store side (D, read/write).
- Sits between the core and RAM/ROM; needed once loads/stores are added to the single-cycle core, which then stalls on ack.
- Fixed D-over-I priority with an anti-starvation streak limit, plus a bus timeout that returns an error response.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- D_STREAK_MAX, 4, max consecutive D grants while I is pending before I is forced; must be >=1.
- TIMEOUT, 255, cycles in a BUSY state without mem_ack before an error response; must be >=2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  AW  fetch byte address
- i_ack  out  1  one-cycle response pulse
- i_rdata  out  DW  fetch data; valid with i_ack
- i_err  out  1  timeout flag; valid with i_ack
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data byte address
- d_wdata  in  DW  write data
- d_be  in  DW/8  byte enables
- d_ack  out  1  one-cycle response pulse
- d_rdata  out  DW  read data; valid with d_ack; 0 on writes
- d_err  out  1  timeout flag; valid with d_ack
- mem_req  out  1  memory request; held until mem_ack or timeout
- mem_we  out  1  write strobe
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_be  out  DW/8  byte enables; all ones for I reads
- mem_ack  in  1  memory completion; honoured only while mem_req=1
- mem_rdata  in  DW  read data; valid with mem_ack

Behaviour:
- All outputs registered. Reset: state IDLE, every output 0, streak=0, timer=0. Reset mid-transaction aborts it with no ack to either side.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - d_req and (streak < D_STREAK_MAX or !i_req) -> BUSY_D; else i_req -> BUSY_I.
  - On grant, latch the requester's fields into mem_* and set mem_req=1 next cycle. Grant-to-mem_req latency is 1 cycle.
- Streak rules:
  - Increments on each D grant made while i_req=1, saturating at D_STREAK_MAX.
  - Clears on any I grant.
  - Clears on a D grant made while i_req=0.
- BUSY_x:
  - mem_ack=1 -> capture mem_rdata (0 for writes), drop mem_req, go to RESP_x.
  - Timer counts from 0 on entry. Reaching TIMEOUT-1 without mem_ack -> drop mem_req, data=0, err=1, go to RESP_x.
  - A mem_ack in the same cycle as the timeout has priority over the timeout (normal response).
- RESP_x:
  - x_ack=1 for exactly one cycle with x_rdata/x_err, then IDLE. No arbitration in RESP.
  - Requester drops req, or presents a new request, in the cycle after ack. A req seen in IDLE is always a new request.
- Best-case round trip: request cycle 0, mem_req cycle 1, mem_ack cycle 1, x_ack cycle 2, next grant possible from cycle 3.
- mem_* fields are stable for the whole time mem_req=1. Requester input changes during BUSY are ignored.
- x_rdata/x_err hold their value after ack until the next response. x_err clears on the next normal response.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Shared package nova_bus_pkg holds:
  - state encoding localparams (ST_IDLE..ST_RESP_D);
  - default AW/DW;
  - the all-ones byte-enable constant.
- One sub-module: bus_timeout_counter (clear/enable/expired, TIMEOUT parameter). The rest stays flat.

Test Plan:
- I read of 0x0000_0010, memory acks after 1 cycle with 0xDEAD_BEEF -> mem_req one cycle after i_req; i_ack two cycles after i_req with i_rdata=0xDEAD_BEEF, i_err=0.
- I and D requests in the same cycle, D write 0x1234_5678 to 0x100 with be=4'b0011 -> D served first (mem_we=1, mem_be=0011), then I; exactly one ack each.
- D_STREAK_MAX=4, d_req held continuously with new requests and i_req pending -> grants D,D,D,D,I,D.
- TIMEOUT=8, mem_ack never asserted on a D read -> mem_req drops after 8 BUSY cycles; d_ack=1 with d_err=1, d_rdata=0; next request completes with err=0.
- Reset asserted during BUSY_I -> next cycle mem_req=0, state IDLE, no i_ack; a fresh request afterwards completes normally.
- Stray mem_ack in IDLE, and I inputs changed mid-BUSY_I -> no ack and no state change in IDLE; mem_addr stays at the originally latched address.
